// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the nibble-serial adder
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index; a single nibble still needs a 1-bit counter.
  function automatic int idx_width(input int nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// rtl/nibble_serial_adder_rca.sv - 4-bit combinational ripple-carry adder (module rca)
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic c1, c2, c3;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign c2   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  assign s[2] = a[2] ^ b[2] ^ c2;
  assign c3   = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);
  assign s[3] = a[3] ^ b[3] ^ c3;
  assign cout = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-precision adder, one nibble per clock; SERIAL_ADD_OVF_EN adds out_ovf
module nibble_serial_adder
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                      out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic                      out_ovf,
`endif
  output logic                      busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state_q, state_d;

  logic [W-1:0]     a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c4;
  logic             last_nib;

  assign last_nib = (idx_q == LAST_IDX);

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end

  rca u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c4)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept only from IDLE, finish after the top nibble, release on consumer accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    begin out_valid = 1'b1; busy = 1'b1; end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load operands on accept, accumulate one sum nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) sum_q[NIBBLE_W*i +: NIBBLE_W] <= s_nib;
      end
      carry_q <= c4;
      if (last_nib) cout_q <= c4;
      else          idx_q  <= idx_q + 1'b1;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Signed overflow: like-signed operands producing a result of the other sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state_q == RUN && last_nib)
      ovf_q <= (a_nib[3] == b_nib[3]) && (s_nib[3] != a_nib[3]);
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1)
module tb_nibble_serial_adder;

  localparam int N  = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0, out_sum;
  logic          out_valid, out_ready = 1'b0, out_cout, busy;
  logic          out_ovf;

  logic          v1 = 1'b0, rdy1, cin1 = 1'b0, ov1, or1 = 1'b0, co1, busy1;
  logic [3:0]    a1 = '0, b1 = '0, s1;
  logic          ovf1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .in_cin(cin1),
    .out_valid(ov1), .out_ready(or1),
    .out_sum(s1), .out_cout(co1),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf(ovf1),
`endif
    .busy(busy1)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign out_ovf = 1'b0;
  assign ovf1    = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full operation on the 4-nibble instance; hold = DONE cycles with out_ready low.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
    logic [W:0]   full;
    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf;
    int           cyc;
    full     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);

    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    check("busy_run", busy, 1'b1);
    check("in_ready_run", in_ready, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < N + 4) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, N);
    check("sum", out_sum, exp_sum);
    check("cout", out_cout, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", out_ovf, exp_ovf);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_sum", out_sum, exp_sum);
    end
    out_ready = 1'b1;
    in_valid  = (hold > 0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_busy", busy, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
  endtask

  // Full operation on the single-nibble instance.
  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    int         cyc;
    full = {1'b0, a} + {1'b0, b} + 5'(cin);
    @(negedge clk);
    check("n1_in_ready", rdy1, 1'b1);
    v1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
    @(negedge clk);
    v1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    cyc = 0;
    while (!ov1 && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    check("n1_latency", cyc, 1);
    check("n1_sum", s1, full[3:0]);
    check("n1_cout", co1, full[4]);
`ifdef SERIAL_ADD_OVF_EN
    check("n1_ovf", ovf1, (a[3] == b[3]) && (full[3] != a[3]));
`endif
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    check("n1_release", ov1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", out_ovf, 1'b0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 2);
    do_op(16'hA5C3, 16'h1E2F, 1'b1, 10);

    // Reset in the middle of RUN, after two nibbles have been produced.
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_busy", busy, 1'b1);
    check("midrun_partial", out_sum[7:0], 8'hFF);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 1'b0);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_sum", out_sum, 16'h0);
    check("midrun_rst_cout", out_cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 20; k++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    op1(4'hF, 4'h1, 1'b1);
    op1(4'h7, 4'h1, 1'b0);
    for (int k = 0; k < 8; k++)
      op1(4'($urandom), 4'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
